// File: rtl/instr_register_pkg.sv
// Shared opcode and FSM state types for the executing instruction register.
// Types here are width-fixed; anything sized from OP_W lives in the top.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV_BUSY,
    WB
  } exec_state_t;

  localparam opcode_t OPC_LAST = MOD;

  function automatic logic is_div_op(input logic [3:0] opc);
    return (opc == DIV) || (opc == MOD);
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses exactly
// W cycles after the start cycle; results hold until the next start.
module iter_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, quo_q, dsr_q;
  logic          busy_q, done_q;
  logic [W:0]    shifted, diff;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign shifted = {rem_q, quo_q[W-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(W);
        rem_q  <= '0;
        quo_q  <= dividend;
        dsr_q  <= divisor;
      end else if (busy_q) begin
        if (!diff[W]) begin
          rem_q <= diff[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register that computes each result before write-back: single-cycle
// ALU for ZERO..MULT, iterative divider for DIV/MOD behind a valid/ready load port.
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int OP_W     = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit AUTO_INC = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_en,
  output logic                   load_ready,
  input  logic [3:0]             opcode,
  input  logic signed [OP_W-1:0] operand_a,
  input  logic signed [OP_W-1:0] operand_b,
  input  logic [ADDR_W-1:0]      write_pointer,
  input  logic [ADDR_W-1:0]      read_pointer,
  output logic [4*OP_W+3:0]      instruction_word,
  output logic                   entry_valid,
  output logic                   wr_done,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   div_zero,
  output logic                   illegal_op
);

  typedef struct packed {
    opcode_t                  opc;
    logic signed [OP_W-1:0]   op_a;
    logic signed [OP_W-1:0]   op_b;
    logic signed [2*OP_W-1:0] res;
  } instr_t;

  exec_state_t state_q, state_d;

  instr_t                 mem_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [3:0]             opc_q;
  logic signed [OP_W-1:0] a_q, b_q;
  logic [ADDR_W-1:0]      addr_q, wr_ptr_q, waddr;
  logic                   wr_done_q, div_zero_q, illegal_q;

  logic                   accept, div_start, wr_en;
  logic                   dz, ill;
  logic [2*OP_W-1:0]      ea, eb, alu_res, div_res, wr_res;
  logic [2*OP_W-1:0]      qmag, rmag;

  logic [OP_W-1:0]        ua, ub, dvd, dvs, quo, rem;
  logic                   div_busy, div_done;

  // The divider sees magnitudes straight from the inputs so it starts on the
  // accept edge; the captured sign bits fix the result up afterwards.
  assign ua  = operand_a;
  assign ub  = operand_b;
  assign dvd = operand_a[OP_W-1] ? -ua : ua;
  assign dvs = operand_b[OP_W-1] ? -ub : ub;

  iter_divider #(.W(OP_W)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (dvd),
    .divisor   (dvs),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    ea      = {{OP_W{a_q[OP_W-1]}}, a_q};
    eb      = {{OP_W{b_q[OP_W-1]}}, b_q};
    qmag    = {{OP_W{1'b0}}, quo};
    rmag    = {{OP_W{1'b0}}, rem};
    alu_res = '0;
    dz      = 1'b0;
    ill     = (opc_q > OPC_LAST);
    case (opc_q)
      PASSA:   alu_res = ea;
      PASSB:   alu_res = eb;
      ADD:     alu_res = ea + eb;
      SUB:     alu_res = ea - eb;
      MULT:    alu_res = ea * eb;
      DIV,
      MOD:     dz      = (b_q == '0);
      default: alu_res = '0;
    endcase
    // Quotient truncates toward zero; remainder takes the sign of a.
    if (opc_q == MOD)
      div_res = a_q[OP_W-1] ? -rmag : rmag;
    else
      div_res = (a_q[OP_W-1] ^ b_q[OP_W-1]) ? -qmag : qmag;
  end

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    accept     = 1'b0;
    div_start  = 1'b0;
    wr_en      = 1'b0;
    wr_res     = alu_res;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_en) begin
          accept = 1'b1;
          if (is_div_op(opcode) && (operand_b != '0)) begin
            div_start = 1'b1;
            state_d   = DIV_BUSY;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      DIV_BUSY: begin
        if (div_done) begin
          wr_en   = 1'b1;
          wr_res  = div_res;
          state_d = WB;
        end else if (!div_busy) begin
          state_d = IDLE;  // divider lost its job; never wait forever
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign waddr = AUTO_INC ? wr_ptr_q : addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      opc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      wr_done_q  <= 1'b0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
      wr_addr    <= '0;
    end else begin
      state_q    <= state_d;
      wr_done_q  <= wr_en;
      div_zero_q <= wr_en & dz;
      illegal_q  <= wr_en & ill;
      if (accept) begin
        opc_q  <= opcode;
        a_q    <= operand_a;
        b_q    <= operand_b;
        addr_q <= write_pointer;
      end
      if (wr_en) begin
        wr_addr <= waddr;
        if (AUTO_INC) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q <= '0;
    end else if (wr_en) begin
      mem_q[waddr].opc  <= ill ? ZERO : opcode_t'(opc_q);
      mem_q[waddr].op_a <= a_q;
      mem_q[waddr].op_b <= b_q;
      mem_q[waddr].res  <= wr_res;
      valid_q[waddr]    <= 1'b1;
    end
  end

  assign instruction_word = mem_q[read_pointer];
  assign entry_valid      = valid_q[read_pointer];
  assign wr_done          = wr_done_q;
  assign div_zero         = div_zero_q;
  assign illegal_op       = illegal_q;

endmodule

// File: tb/tb_instr_register_exec.sv
// Directed bench: vector table through the addressed-mode instance, hand-written
// sequences for reset-mid-division, held load_en, read-during-write and auto mode.
module tb_instr_register_exec;
  import instr_register_pkg::*;

  typedef struct packed {
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } iw_t;

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic [63:0] res;
    logic [3:0]  sopc;
    logic        dz;
    logic        ill;
    int          lat;
  } vec_t;

  logic         clk, reset_n;
  logic         load_en, load_ready;
  logic [3:0]   opcode;
  logic [31:0]  operand_a, operand_b;
  logic [4:0]   write_pointer, read_pointer;
  logic [131:0] instruction_word;
  logic         entry_valid, wr_done, div_zero, illegal_op;
  logic [4:0]   wr_addr;

  logic         a_load_en, a_ready;
  logic [3:0]   a_opcode;
  logic [31:0]  a_a, a_b;
  logic [1:0]   a_wp, a_rp, a_waddr;
  logic [131:0] a_word;
  logic         a_valid, a_done, a_dz, a_ill;

  int checks = 0;
  int failures = 0;

  instr_register_exec #(.OP_W(32), .DEPTH(32), .AUTO_INC(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_ready(load_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .entry_valid(entry_valid),
    .wr_done(wr_done), .wr_addr(wr_addr), .div_zero(div_zero), .illegal_op(illegal_op)
  );

  instr_register_exec #(.OP_W(32), .DEPTH(4), .AUTO_INC(1'b1)) dut_auto (
    .clk(clk), .reset_n(reset_n), .load_en(a_load_en), .load_ready(a_ready),
    .opcode(a_opcode), .operand_a(a_a), .operand_b(a_b),
    .write_pointer(a_wp), .read_pointer(a_rp),
    .instruction_word(a_word), .entry_valid(a_valid),
    .wr_done(a_done), .wr_addr(a_waddr), .div_zero(a_dz), .illegal_op(a_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    int  bad;
    iw_t w;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      read_pointer = 5'(i);
      #1;
      w = instruction_word;
      if (w !== '0 || entry_valid !== 1'b0) bad++;
    end
    check({tag, "_entries"}, 64'(bad), 64'd0);
    check({tag, "_ready"}, 64'(load_ready), 64'd1);
    check({tag, "_wr_done"}, 64'(wr_done), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_flags"}, {62'd0, div_zero, illegal_op}, 64'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_load(input int idx, input vec_t v);
    int   lat;
    logic got, ready_bad;
    iw_t  w;
    string n;
    n = $sformatf("v%0d", idx);
    wait_ready();
    opcode = v.opc; operand_a = v.a; operand_b = v.b; write_pointer = v.addr;
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
    ready_bad = load_ready;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk);
      #1;
      if (wr_done) begin
        got = 1'b1;
        lat = c;
      end else if (load_ready) begin
        ready_bad = 1'b1;
      end
    end
    check({n, "_done"}, 64'(got), 64'd1);
    if (got) begin
      check({n, "_lat"}, 64'(lat), 64'(v.lat));
      check({n, "_wr_addr"}, 64'(wr_addr), 64'(v.addr));
      check({n, "_div_zero"}, 64'(div_zero), 64'(v.dz));
      check({n, "_illegal"}, 64'(illegal_op), 64'(v.ill));
      check({n, "_ready_low"}, 64'(ready_bad), 64'd0);
      read_pointer = v.addr;
      #1;
      w = instruction_word;
      check({n, "_res"}, w.res, v.res);
      check({n, "_opc"}, 64'(w.opc), 64'(v.sopc));
      check({n, "_op_a"}, 64'(w.a), 64'(v.a));
      check({n, "_valid"}, 64'(entry_valid), 64'd1);
    end
  endtask

  vec_t vecs [14];

  initial begin
    iw_t         w;
    int          pulses, first, n;
    logic        seen;
    logic [1:0]  exp_wa [5];
    logic [63:0] exp_auto [4];

    vecs[0]  = '{ADD,   32'd7,        -32'sd3,      5'd5,  64'sd4,                  ADD,   1'b0, 1'b0, 1};
    vecs[1]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 5'd6, 64'h4000_0000_0000_0000, MULT,  1'b0, 1'b0, 1};
    vecs[2]  = '{DIV,   -32'sd7,      32'd2,        5'd7,  -64'sd3,                 DIV,   1'b0, 1'b0, 33};
    vecs[3]  = '{MOD,   -32'sd7,      32'd2,        5'd8,  -64'sd1,                 MOD,   1'b0, 1'b0, 33};
    vecs[4]  = '{DIV,   32'h8000_0000, -32'sd1,     5'd9,  64'h0000_0000_8000_0000, DIV,   1'b0, 1'b0, 33};
    vecs[5]  = '{DIV,   32'd5,        32'd0,        5'd10, 64'd0,                   DIV,   1'b1, 1'b0, 1};
    vecs[6]  = '{4'd12, 32'd3,        32'd4,        5'd11, 64'd0,                   ZERO,  1'b0, 1'b1, 1};
    vecs[7]  = '{SUB,   32'd5,        32'd9,        5'd12, -64'sd4,                 SUB,   1'b0, 1'b0, 1};
    vecs[8]  = '{PASSB, 32'd1,        -32'sd8,      5'd13, -64'sd8,                 PASSB, 1'b0, 1'b0, 1};
    vecs[9]  = '{MOD,   32'd7,        -32'sd2,      5'd14, 64'sd1,                  MOD,   1'b0, 1'b0, 33};
    vecs[10] = '{MOD,   32'd5,        32'd0,        5'd15, 64'd0,                   MOD,   1'b1, 1'b0, 1};
    vecs[11] = '{PASSA, -32'sd5,      32'd1,        5'd16, -64'sd5,                 PASSA, 1'b0, 1'b0, 1};
    vecs[12] = '{MULT,  32'd123456,   -32'sd1000,   5'd17, -64'sd123456000,         MULT,  1'b0, 1'b0, 1};
    vecs[13] = '{ZERO,  32'd9,        32'd9,        5'd18, 64'd0,                   ZERO,  1'b0, 1'b0, 1};

    reset_n = 1'b0;
    load_en = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    write_pointer = '0; read_pointer = '0;
    a_load_en = 1'b0; a_opcode = '0; a_a = '0; a_b = '0; a_wp = 2'd3; a_rp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check_reset("reset");

    // Reset partway through a division: no write may land.
    wait_ready();
    opcode = DIV; operand_a = 32'd100; operand_b = 32'd7; write_pointer = 5'd3;
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("midreset_ready_in_reset", 64'(load_ready), 64'd1);
    @(negedge clk) reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (wr_done) pulses++;
    end
    check("midreset_no_write", 64'(pulses), 64'd0);
    check_reset("midreset");

    for (int i = 0; i < 14; i++) do_load(i, vecs[i]);

    // load_en held high for the whole division: exactly one write.
    wait_ready();
    opcode = DIV; operand_a = 32'd100; operand_b = 32'd7; write_pointer = 5'd20;
    load_en = 1'b1;
    pulses = 0; first = 0; seen = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (wr_done) pulses++;
      if (wr_done && !seen) begin
        seen = 1'b1;
        first = c;
        @(negedge clk) load_en = 1'b0;
      end
    end
    load_en = 1'b0;
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_lat", 64'(first), 64'd34);
    read_pointer = 5'd20;
    #1 w = instruction_word;
    check("hold_res", w.res, 64'd14);

    // Read of addr 5 across its own write edge: old value, then new.
    wait_ready();
    opcode = PASSA; operand_a = 32'd77; operand_b = 32'd0; write_pointer = 5'd5;
    read_pointer = 5'd5;
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
    w = instruction_word;
    check("rdw_old_after_accept", w.res, 64'd4);
    @(negedge clk);
    w = instruction_word;
    check("rdw_old_before_write", w.res, 64'd4);
    @(posedge clk);
    #1 w = instruction_word;
    check("rdw_new_after_write", w.res, 64'd77);
    check("rdw_wr_done", 64'(wr_done), 64'd1);

    // Auto-increment instance: five writes wrap onto entry 0.
    exp_wa   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_auto = '{64'd5, 64'd2, 64'd3, 64'd4};
    for (int k = 1; k <= 5; k++) begin
      n = 0;
      @(negedge clk);
      while (a_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      a_opcode = PASSA; a_a = 32'(k); a_b = 32'd0; a_load_en = 1'b1;
      @(posedge clk);
      #1 a_load_en = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk);
        #1 if (a_done) seen = 1'b1;
      end
      check($sformatf("auto_done_%0d", k), 64'(seen), 64'd1);
      check($sformatf("auto_wr_addr_%0d", k), 64'(a_waddr), 64'(exp_wa[k-1]));
    end
    for (int e = 0; e < 4; e++) begin
      a_rp = 2'(e);
      #1 w = a_word;
      check($sformatf("auto_entry_%0d", e), w.res, exp_auto[e]);
      check($sformatf("auto_valid_%0d", e), 64'(a_valid), 64'd1);
    end
    check("auto_flags", {62'd0, a_dz, a_ill}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
